// File: rtl/frame_ram_arbiter.sv
// Frame RAM arbiter: shares one single-port row-wide RAM between a pixel
// painter (read-modify-write of a single bit), a row loader (whole-row read)
// and a frame clear (write zero to every row). Every output is a flop.
module frame_ram_arbiter #(
   parameter int ROWS = 480,
   parameter int COLS = 640
) (
   input  logic            CLOCK_50,
   input  logic            reset_n,
   input  logic            pix_req,
   input  logic [9:0]      pix_x,
   input  logic [8:0]      pix_y,
   input  logic            pix_color,
   output logic            pix_ack,
   input  logic            row_req,
   input  logic [8:0]      row_addr,
   output logic            row_valid,
   output logic [COLS-1:0] row_data,
   input  logic            clr_req,
   output logic            clr_done,
   output logic            busy,
   output logic [8:0]      ram_addr,
   output logic            ram_wren,
   output logic [COLS-1:0] ram_wdata,
   input  logic [COLS-1:0] ram_q
);

   typedef enum logic [2:0] {
      IDLE, ROW_RD, ROW_CAP, PIX_RD, PIX_CAP, PIX_WR, CLEAR
   } state_t;

   // Range limits widened by one bit so a depth/width of 2**N still compares correctly.
   localparam logic [9:0]  ROWS_L   = 10'(ROWS);
   localparam logic [10:0] COLS_L   = 11'(COLS);
   localparam logic [8:0]  LAST_ROW = 9'(ROWS - 1);

   state_t          state_q, state_d;
   logic [8:0]      ram_addr_q, ram_addr_d;
   logic            ram_wren_q, ram_wren_d;
   logic [COLS-1:0] ram_wdata_q, ram_wdata_d;
   logic [COLS-1:0] row_data_q, row_data_d;
   logic            row_valid_q, row_valid_d;
   logic            pix_ack_q, pix_ack_d;
   logic            clr_done_q, clr_done_d;
   logic            busy_q, busy_d;
   logic            last_pix_q, last_pix_d;   // 1: last row/pix grant went to the painter
   logic [9:0]      px_x_q, px_x_d;
   logic            px_c_q, px_c_d;
   logic            discard_q, discard_d;     // out-of-range request: pulse only, no RAM use
   logic [8:0]      clr_cnt_q, clr_cnt_d;

   logic            clr_go, row_go, pix_go;
   logic            row_oob, pix_oob;
   logic [COLS-1:0] merged_w;

   // A requester holds its level until its pulse, so mask it during that pulse cycle.
   assign clr_go  = clr_req & ~clr_done_q;
   assign row_go  = row_req & ~row_valid_q;
   assign pix_go  = pix_req & ~pix_ack_q;
   assign row_oob = {1'b0, row_addr} >= ROWS_L;
   assign pix_oob = ({1'b0, pix_x} >= COLS_L) | ({1'b0, pix_y} >= ROWS_L);

   // Read word with only the latched pixel bit replaced.
   always_comb begin
      merged_w         = ram_q;
      merged_w[px_x_q] = px_c_q;
   end

   // Next-state and next-output computation for the arbitration FSM.
   always_comb begin
      state_d     = state_q;
      ram_addr_d  = ram_addr_q;
      ram_wren_d  = 1'b0;
      ram_wdata_d = ram_wdata_q;
      row_data_d  = row_data_q;
      row_valid_d = 1'b0;
      pix_ack_d   = 1'b0;
      clr_done_d  = 1'b0;
      last_pix_d  = last_pix_q;
      px_x_d      = px_x_q;
      px_c_d      = px_c_q;
      discard_d   = discard_q;
      clr_cnt_d   = clr_cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_go) begin
               state_d     = CLEAR;
               ram_addr_d  = '0;
               ram_wdata_d = '0;
               ram_wren_d  = 1'b1;
               clr_cnt_d   = '0;
            end else if (row_go && (!pix_go || last_pix_q)) begin
               last_pix_d = 1'b0;
               discard_d  = row_oob;
               if (row_oob) begin
                  state_d = ROW_CAP;
               end else begin
                  state_d    = ROW_RD;
                  ram_addr_d = row_addr;
               end
            end else if (pix_go) begin
               last_pix_d = 1'b1;
               px_x_d     = pix_x;
               px_c_d     = pix_color;
               discard_d  = pix_oob;
               if (pix_oob) begin
                  state_d = PIX_WR;
               end else begin
                  state_d    = PIX_RD;
                  ram_addr_d = pix_y;
               end
            end
         end
         ROW_RD:  state_d = ROW_CAP;
         ROW_CAP: begin
            row_data_d  = discard_q ? '0 : ram_q;
            row_valid_d = 1'b1;
            state_d     = IDLE;
         end
         PIX_RD:  state_d = PIX_CAP;
         PIX_CAP: begin
            ram_wdata_d = merged_w;
            ram_wren_d  = 1'b1;
            state_d     = PIX_WR;
         end
         PIX_WR: begin
            pix_ack_d = 1'b1;
            state_d   = IDLE;
         end
         CLEAR: begin
            if (clr_cnt_q == LAST_ROW) begin
               clr_done_d = 1'b1;
               state_d    = IDLE;
            end else begin
               clr_cnt_d  = clr_cnt_q + 9'd1;
               ram_addr_d = ram_addr_q + 9'd1;
               ram_wren_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ram_addr_q  <= '0;
         ram_wren_q  <= 1'b0;
         ram_wdata_q <= '0;
         row_data_q  <= '0;
         row_valid_q <= 1'b0;
         pix_ack_q   <= 1'b0;
         clr_done_q  <= 1'b0;
         busy_q      <= 1'b0;
         last_pix_q  <= 1'b1;
         px_x_q      <= '0;
         px_c_q      <= 1'b0;
         discard_q   <= 1'b0;
         clr_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         ram_wren_q  <= ram_wren_d;
         ram_wdata_q <= ram_wdata_d;
         row_data_q  <= row_data_d;
         row_valid_q <= row_valid_d;
         pix_ack_q   <= pix_ack_d;
         clr_done_q  <= clr_done_d;
         busy_q      <= busy_d;
         last_pix_q  <= last_pix_d;
         px_x_q      <= px_x_d;
         px_c_q      <= px_c_d;
         discard_q   <= discard_d;
         clr_cnt_q   <= clr_cnt_d;
      end
   end

   assign pix_ack   = pix_ack_q;
   assign row_valid = row_valid_q;
   assign row_data  = row_data_q;
   assign clr_done  = clr_done_q;
   assign busy      = busy_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wren  = ram_wren_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Bench for frame_ram_arbiter: RAM model with registered read, frame-level
// reference model, directed scenarios followed by random transactions.
module tb_frame_ram_arbiter;
   localparam int ROWS = 480;
   localparam int COLS = 640;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            pix_req = 1'b0, pix_color = 1'b0, pix_ack;
   logic [9:0]      pix_x = '0;
   logic [8:0]      pix_y = '0;
   logic            row_req = 1'b0, row_valid;
   logic [8:0]      row_addr = '0;
   logic [COLS-1:0] row_data;
   logic            clr_req = 1'b0, clr_done, busy;
   logic [8:0]      ram_addr;
   logic            ram_wren;
   logic [COLS-1:0] ram_wdata, ram_q;

   always #10 clk = ~clk;

   frame_ram_arbiter #(.ROWS(ROWS), .COLS(COLS)) dut (
      .CLOCK_50(clk), .reset_n(reset_n),
      .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_ack(pix_ack),
      .row_req(row_req), .row_addr(row_addr), .row_valid(row_valid), .row_data(row_data),
      .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_q(ram_q)
   );

   typedef struct { int addr; logic [COLS-1:0] data; int cyc; } wr_t;

   logic [COLS-1:0] ram_mem [0:511];
   logic [COLS-1:0] ref_frame [0:ROWS-1];
   wr_t             wq[$];
   wr_t             w_tmp;
   int              cyc = 0;
   int              ack_cnt = 0;
   logic            bk_en = 1'b0;
   logic [8:0]      bk_addr = '0;
   logic [COLS-1:0] bk_data = '0;
   int              checks = 0;
   int              failures = 0;

   // RAM model plus write log and ack counter.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bk_en) ram_mem[bk_addr] <= bk_data;
      else if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
      ram_q <= ram_mem[ram_addr];
      if (ram_wren) begin
         w_tmp.addr = int'(ram_addr);
         w_tmp.data = ram_wdata;
         w_tmp.cyc  = cyc;
         wq.push_back(w_tmp);
      end
      if (pix_ack) ack_cnt <= ack_cnt + 1;
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk_i(input string tag, input integer obs, input integer exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [COLS-1:0] obs, input logic [COLS-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clear_seq_errors(input int w0);
      int bad = 0;
      for (int i = 0; i < ROWS && (w0 + i) < wq.size(); i++)
         if (wq[w0+i].addr != i || wq[w0+i].data !== '0 || wq[w0+i].cyc != wq[w0].cyc + i)
            bad++;
      return bad;
   endfunction

   task automatic pix_txn(input int x, input int y, input bit c);
      int n = 0;
      bit got = 0;
      bit valid = (x < COLS) && (y < ROWS);
      int w0 = wq.size();
      logic [COLS-1:0] exp;
      @(negedge clk);
      pix_x = 10'(x); pix_y = 9'(y); pix_color = c; pix_req = 1'b1;
      while (!got && n < 20) begin @(posedge clk); #1; n++; got = pix_ack; end
      pix_req = 1'b0;
      chk_i("pix_ack_seen", 32'(got), 1);
      chk_i("pix_ack_latency", n, valid ? 4 : 2);
      if (valid) begin
         exp = ref_frame[y];
         exp[x] = c;
         ref_frame[y] = exp;
         chk_i("pix_write_count", wq.size() - w0, 1);
         if (wq.size() == w0 + 1) begin
            chk_i("pix_write_addr", wq[w0].addr, y);
            chk_w("pix_write_data", wq[w0].data, exp);
         end
      end else begin
         chk_i("pix_discard_no_write", wq.size() - w0, 0);
      end
      @(posedge clk); #1;
      chk_i("pix_ack_single", 32'(pix_ack), 0);
      $display("pix x=%0d y=%0d c=%0d latency=%0d", x, y, c, n);
   endtask

   task automatic row_txn(input int a);
      int n = 0;
      bit got = 0;
      bit valid = (a < ROWS);
      int w0 = wq.size();
      int a0 = int'(ram_addr);
      logic [COLS-1:0] exp = valid ? ref_frame[a] : '0;
      @(negedge clk);
      row_addr = 9'(a); row_req = 1'b1;
      while (!got && n < 20) begin @(posedge clk); #1; n++; got = row_valid; end
      row_req = 1'b0;
      chk_i("row_valid_seen", 32'(got), 1);
      chk_i("row_latency", n, valid ? 3 : 2);
      chk_w("row_data", row_data, exp);
      chk_i("row_no_write", wq.size() - w0, 0);
      if (!valid) chk_i("row_oob_no_ram_access", int'(ram_addr), a0);
      @(posedge clk); #1;
      chk_i("row_valid_single", 32'(row_valid), 0);
      chk_w("row_data_stable", row_data, exp);
      $display("row addr=%0d latency=%0d", a, n);
   endtask

   task automatic clear_txn();
      int n = 0;
      bit got = 0;
      int w0 = wq.size();
      @(negedge clk);
      clr_req = 1'b1;
      while (!got && n < 600) begin @(posedge clk); #1; n++; got = clr_done; end
      clr_req = 1'b0;
      chk_i("clr_done_seen", 32'(got), 1);
      chk_i("clr_latency", n, ROWS + 1);
      chk_i("clr_write_count", wq.size() - w0, ROWS);
      chk_i("clr_write_seq", clear_seq_errors(w0), 0);
      for (int r = 0; r < ROWS; r++) ref_frame[r] = '0;
      @(posedge clk); #1;
      chk_i("clr_done_single", 32'(clr_done), 0);
      $display("clear latency=%0d writes=%0d", n, wq.size() - w0);
   endtask

   task automatic frame_compare(input string tag);
      int bad = 0;
      for (int r = 0; r < ROWS; r++) if (ram_mem[r] !== ref_frame[r]) bad++;
      chk_i(tag, bad, 0);
      $display("frame compare %s bad_rows=%0d", tag, bad);
   endtask

   initial begin
      int n, k, w0, a0, x, y, r, exp_pix, total;
      int seq [4];
      bit c, got;
      logic [COLS-1:0] rowv;

      // Fill RAM with random content while the DUT is held in reset.
      @(negedge clk);
      bk_en = 1'b1;
      for (int i = 0; i < ROWS; i++) begin
         for (int wd = 0; wd < COLS / 32; wd++) rowv[wd*32 +: 32] = $urandom;
         bk_addr = 9'(i); bk_data = rowv; ref_frame[i] = rowv;
         @(negedge clk);
      end
      bk_en = 1'b0;
      @(negedge clk);

      // Reset values.
      chk_i("rst_busy", 32'(busy), 0);
      chk_i("rst_wren", 32'(ram_wren), 0);
      chk_i("rst_addr", 32'(ram_addr), 0);
      chk_w("rst_wdata", ram_wdata, '0);
      chk_w("rst_row_data", row_data, '0);
      chk_i("rst_pix_ack", 32'(pix_ack), 0);
      chk_i("rst_row_valid", 32'(row_valid), 0);
      chk_i("rst_clr_done", 32'(clr_done), 0);
      $display("reset values checked");
      reset_n = 1'b1;

      // Row and pixel requests asserted together and held: row first, then alternating.
      y = $urandom_range(0, ROWS - 1);
      x = $urandom_range(0, COLS - 1);
      c = ~ref_frame[y][x];
      w0 = wq.size();
      k = 0; n = 0;
      row_addr = 9'(y); pix_x = 10'(x); pix_y = 9'(y); pix_color = c;
      row_req = 1'b1; pix_req = 1'b1;
      while (k < 4 && n < 40) begin
         @(posedge clk); #1; n++;
         if (row_valid) begin
            chk_w("rr_row_data", row_data, ref_frame[y]);
            if (k < 4) seq[k] = 0;
            k++;
         end
         if (pix_ack) begin
            ref_frame[y][x] = c;
            if (k < 4) seq[k] = 1;
            k++;
         end
      end
      row_req = 1'b0; pix_req = 1'b0;
      chk_i("rr_pulses", k, 4);
      chk_i("rr_writes", wq.size() - w0, 2);
      exp_pix = 1;
      for (int i = 0; i < 4 && i < k; i++) begin
         exp_pix = 1 - exp_pix;
         chk_i("rr_order", seq[i], exp_pix);
         $display("rr grant %0d kind=%s", i, seq[i] == 1 ? "pix" : "row");
      end
      @(posedge clk);

      // Clear with a pixel request pending: clear wins, then the RMW.
      w0 = wq.size();
      n = 0; got = 0;
      @(negedge clk);
      pix_x = 10'd100; pix_y = 9'd200; pix_color = 1'b1;
      clr_req = 1'b1; pix_req = 1'b1;
      while (!got && n < 600) begin @(posedge clk); #1; n++; got = clr_done; end
      clr_req = 1'b0;
      chk_i("cp_clr_done_seen", 32'(got), 1);
      chk_i("cp_clr_latency", n, ROWS + 1);
      chk_i("cp_clr_write_count", wq.size() - w0, ROWS);
      chk_i("cp_clr_write_seq", clear_seq_errors(w0), 0);
      for (int i = 0; i < ROWS; i++) ref_frame[i] = '0;
      n = 0; got = 0;
      while (!got && n < 20) begin @(posedge clk); #1; n++; got = pix_ack; end
      pix_req = 1'b0;
      chk_i("cp_pix_ack_seen", 32'(got), 1);
      chk_i("cp_pix_latency", n, 4);
      ref_frame[200][100] = 1'b1;
      chk_i("cp_pix_write_count", wq.size() - w0, ROWS + 1);
      if (wq.size() == w0 + ROWS + 1) begin
         chk_i("cp_pix_write_addr", wq[w0+ROWS].addr, 200);
         chk_w("cp_pix_write_data", wq[w0+ROWS].data, ref_frame[200]);
      end
      @(posedge clk); #1;
      total = 0;
      for (int i = 0; i < ROWS; i++) total += $countones(ram_mem[i]);
      chk_i("cp_frame_popcount", total, 1);
      frame_compare("cp_frame");
      $display("clear+pix done");

      // Single pixel on a cleared row, read back, out-of-range row and pixels.
      pix_txn(3, 5, 1'b1);
      row_txn(5);
      row_txn(480);
      pix_txn(640, 0, 1'b1);
      pix_txn(5, 480, 1'b1);

      // Reset while in PIX_CAP aborts the write and the ack.
      y = $urandom_range(0, ROWS - 1);
      x = $urandom_range(0, COLS - 1);
      c = ~ref_frame[y][x];
      w0 = wq.size(); a0 = ack_cnt;
      @(negedge clk);
      pix_x = 10'(x); pix_y = 9'(y); pix_color = c; pix_req = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk_i("abort_busy_before", 32'(busy), 1);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk_i("abort_busy_after", 32'(busy), 0);
      chk_i("abort_wren_after", 32'(ram_wren), 0);
      @(negedge clk);
      reset_n = 1'b1; pix_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk_i("abort_no_write", wq.size() - w0, 0);
      chk_i("abort_no_ack", ack_cnt - a0, 0);
      $display("abort during PIX_CAP y=%0d x=%0d", y, x);
      row_txn(y);

      // Random traffic against the frame model.
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 15);
         if (r == 0) begin
            clear_txn();
         end else if (r < 9) begin
            x = ($urandom_range(0, 7) == 0) ? $urandom_range(COLS, 1023) : $urandom_range(0, COLS - 1);
            y = ($urandom_range(0, 7) == 0) ? $urandom_range(ROWS, 511) : $urandom_range(0, ROWS - 1);
            pix_txn(x, y, 1'($urandom_range(0, 1)));
         end else begin
            row_txn(($urandom_range(0, 1) == 0) ? y : $urandom_range(0, 511));
         end
      end

      frame_compare("final_frame");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_ram_arbiter.md
FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 Parameter ROWS, 480, frame rows = RAM depth.
REQ-002 Parameter COLS, 640, pixels per row = RAM word width.
REQ-003 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 pix_req  in  1  painter pixel-write request; level, held until pix_ack.
REQ-006 pix_x  in  10  pixel column; pix_y  in  9  pixel row; pix_color  in  1  pixel value.
REQ-007 pix_ack  out  1  one-cycle pulse: pixel write complete or discarded.
REQ-008 row_req  in  1  loader row-read request; level, held until row_valid.
REQ-009 row_addr  in  9  row to read.
REQ-010 row_valid  out  1  one-cycle pulse; row_data  out  COLS  row contents, stable until next row_valid.
REQ-011 clr_req  in  1  frame-clear request; clr_done  out  1  one-cycle pulse on clear completion.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 ram_addr  out  9, ram_wren  out  1, ram_wdata  out  COLS, ram_q  in  COLS  single-port RAM; ram_q valid one edge after ram_addr is sampled.

Function
REQ-014 FSM states: IDLE, ROW_RD, ROW_CAP, PIX_RD, PIX_CAP, PIX_WR, CLEAR; all outputs registered.
REQ-015 Arbitration in IDLE only: clr_req > {row_req, pix_req}; row/pix round-robin on last_grant bit.
REQ-016 A request is not sampled in the cycle its own row_valid/pix_ack/clr_done is high.
REQ-017 Row read: IDLE->ROW_RD (ram_addr<=row_addr) ->ROW_CAP ->IDLE with row_data<=ram_q, row_valid=1; row_valid 3 edges after grant edge.
REQ-018 row_addr >= ROWS: no RAM access; row_data<=0, row_valid pulse on edge after grant.
REQ-019 Pixel RMW: grant latches pix_x/pix_y/pix_color, ram_addr<=pix_y, ->PIX_RD ->PIX_CAP ->PIX_WR with ram_wdata<=ram_q, bit pix_x replaced by pix_color, ram_wren=1 one cycle ->IDLE with pix_ack=1.
REQ-020 pix_x >= COLS or pix_y >= ROWS: no RAM access, no write; pix_ack pulse on edge after grant.
REQ-021 Only bit pix_x changes in the written word; all other 639 bits equal the read value.
REQ-022 CLEAR: ram_wdata=0, ram_wren=1, ram_addr 0..ROWS-1 one per cycle (ROWS consecutive write cycles); last write ->IDLE, clr_done pulse, wren=0.
REQ-023 CLEAR and RMW are not preemptible; requests arriving meanwhile wait in IDLE arbitration.
REQ-024 ram_wren is high only in PIX_WR and CLEAR; never two writes to one address in a single RMW.
REQ-025 Round-robin: with row_req and pix_req both pending in IDLE, grant alternates; last_grant updates only on row/pix grants.

Reset
REQ-026 reset_n=0 at an edge: state<=IDLE, last_grant<=pix (row wins first tie), ram_wren<=0, ram_addr<=0, ram_wdata<=0, row_data<=0, pix_ack/row_valid/clr_done/busy<=0, clear counter<=0.
REQ-027 Reset mid-RMW or mid-CLEAR aborts without further writes; no ack/done pulse for the aborted operation; requesters re-request.

Verification
REQ-028 RAM row 5 = all 0; pix_req x=3,y=5,color=1 -> one write to addr 5 with only bit 3 set, pix_ack 4 edges after grant.
REQ-029 row_req addr=5 after REQ-028 -> row_valid pulse 3 edges after grant, row_data bit3=1, others 0; row_addr=480 -> row_data=0, no RAM read.
REQ-030 row_req and pix_req asserted together from reset, held -> grant order row,pix,row,pix; each done pulse once per transaction.
REQ-031 clr_req with pix_req pending -> 480 consecutive wren cycles addr 0..479 data 0, clr_done, then pixel RMW; final frame has only that pixel set.
REQ-032 reset_n=0 during PIX_CAP -> no wren, no pix_ack, busy=0 next cycle; RAM row unchanged.
REQ-033 pix_x=640 -> pix_ack on edge after grant, ram_wren never asserted.
